dma_r_ami: RTL and testbench
============================

# dma_r_ami

Read-address/read-data engine between the AXI4 master port and the DMA read datapath (`dma_r_regular`). It accepts one `{dmar_sa, dmar_len}` read command at a time and splits it into AXI INCR bursts that never cross a 4 KB boundary. It keeps up to `OUTS` bursts in flight. It returns the read data on the `dma_r*` stream, with `dma_rlast` marking only the final beat of the whole command.

## Interface
- `AXI_DW`, 128: AXI data width in bits; `BYTES = AXI_DW/8`, `L = log2(BYTES)`.
- `AXI_IW`, 4: AXI ID width.
- `AXI_BL`, 16: maximum beats per burst, 1..256.
- `OUTS`, 4: maximum outstanding bursts, 1..15.
- `usr_clk`  in  1  clock.
- `usr_reset`  in  1  reset, synchronous, active-high.
- `dmar_valid`  in  1  command valid.
- `dmar_ready`  out  1  command ready.
- `dmar_sa`  in  32  read start byte address; bits [L-1:0] ignored.
- `dmar_len`  in  32  read length in bytes.
- `dma_rdata`  out  AXI_DW  read data to downstream.
- `dma_rlast`  out  1  last beat of the command.
- `dma_rvalid`  out  1  data valid.
- `dma_rready`  in  1  downstream ready.
- `m_arid`  out  AXI_IW  constant 0.
- `m_araddr`  out  32  burst address.
- `m_arlen`  out  8  beats-1.
- `m_arsize`  out  3  constant L.
- `m_arburst`  out  2  constant 2'b01 (INCR).
- `m_arvalid`, `m_arready`  out/in  1  AR handshake.
- `m_rdata`  in  AXI_DW  AXI read data.
- `m_rresp`  in  2  AXI read response.
- `m_rlast`  in  1  AXI last beat of burst.
- `m_rvalid`, `m_rready`  in/out  1  R handshake.
- `err_rresp`  out  1  sticky response error (see Configuration).

## Operation
- States:
  - IDLE: `dmar_ready`=1.
  - ADDR: issuing AR.
  - DRAIN: all AR issued, waiting for R.
- Command accept (`dmar_valid & dmar_ready`):
  - latch `addr = dmar_sa[31:L]`.
  - latch `beats = (dmar_len + BYTES-1) >> L`, computed in 33 bits.
  - latch `nburst_left = 0`.
  - IDLE→ADDR; if `beats==0`, stay IDLE, command discarded, no AR, no R.
- Burst size: `b = min(beats_rem, AXI_BL, (4096 - {addr,L'b0}[11:0]) >> L)`.
  - `m_araddr = {addr, L'b0}`, `m_arlen = b-1`.
  - On AR handshake: `addr += b`, `beats_rem -= b`, `outstanding += 1`.
  - When `beats_rem` reaches 0: ADDR→DRAIN.
- `m_arvalid` is asserted in ADDR only when `outstanding < OUTS`.
  - AR fields are held stable while `m_arvalid & !m_arready`.
- R path is combinational pass-through:
  - `dma_rdata = m_rdata`.
  - `dma_rvalid = m_rvalid & (state!=IDLE)`.
  - `m_rready = dma_rready & (state!=IDLE)`.
- On an R handshake with `m_rlast`: `outstanding -= 1`.
  - Simultaneous AR handshake and R-last leaves `outstanding` unchanged.
- `dma_rlast = dma_rvalid & m_rlast & (state==DRAIN) & (outstanding==1)`.
  - When that beat is accepted: DRAIN→IDLE.
- Beats are never dropped or duplicated. `m_rid` is not checked; the interconnect returns in order.

## Timing
- Reset values:
  - `m_arvalid`=0, `m_araddr`=0, `m_arlen`=0.
  - `dma_rvalid`=0, `dma_rlast`=0, `m_rready`=0, `err_rresp`=0.
  - `dmar_ready`=1 (IDLE).
- Command accepted at cycle T: first `m_arvalid` at T+1 (AR fields registered).
- Back-to-back AR handshakes every cycle are allowed while the limit permits.
- R data latency through the block is 0 cycles.
- A new command can be accepted in the cycle after the final `dma_rlast` handshake.
- Reset mid-operation returns to IDLE with the reset values above. The AXI interconnect must be reset in the same cycle.

## Configuration
- `DMA_R_AMI_RRESP_CHK_EN` defined:
  - `err_rresp` sets in the cycle after any R handshake with `m_rresp[1]`=1.
  - It stays set until reset.
  - Data is still forwarded unchanged.
- Not defined: `m_rresp` is ignored and `err_rresp` is tied 0.

## Test plan
- Single burst, `sa`=0x1000, `len`=256, AXI_DW=128 → one AR: `araddr`=0x1000, `arlen`=15; 16 beats forwarded; `dma_rlast` on beat 16 only.
- 4 KB split, `sa`=0x1F80, `len`=512 → three ARs in order:
  - 0x1F80 / `arlen` 7.
  - 0x2000 / `arlen` 15.
  - 0x2100 / `arlen` 7.
  - Total 32 beats; exactly one `dma_rlast`.
- Odd length, `len`=17 → one AR, `arlen`=1; `len`=0 → no AR, `dmar_ready` stays 1.
- OUTS=2, `m_arready`=1, `m_rvalid`=0 with a 4-burst command → exactly 2 ARs issued. The third AR appears the cycle after the first burst's `m_rlast` handshake.
- Random `dma_rready` backpressure on a 64-beat command → `m_rready` tracks `dma_rready`; 64 beats arrive in order, data intact.
- With macro, `m_rresp`=2'b10 on beat 3:
  - `err_rresp`=1 from the next cycle, held until `usr_reset`.
  - All beats still delivered.
  - Without macro, `err_rresp` stays 0.

Source files
------------

// File: rtl/dma_r_ami.sv
// dma_r_ami
//   Read-address / read-data engine between an AXI4 master read port and the
//   DMA read datapath. One {dmar_sa, dmar_len} command is accepted at a time
//   and split into INCR bursts of at most AXI_BL beats that never cross a
//   4 KB boundary. Up to OUTS bursts may be in flight. Read data is passed
//   straight through to the dma_r* stream; dma_rlast marks only the final
//   beat of the whole command.
//
// Optional feature: define DMA_R_AMI_RRESP_CHK_EN to enable the sticky
//   err_rresp flag (set after any R handshake with m_rresp[1]=1, cleared
//   only by reset). Without it m_rresp is ignored and err_rresp is 0.
//
// Ports
//   usr_clk, usr_reset        clock, synchronous active-high reset
//   dmar_valid/ready/sa/len   read command (sa low L bits ignored, len bytes)
//   dma_rdata/rlast/rvalid/rready   read data stream to the datapath
//   m_ar*                     AXI read address channel (id 0, INCR, full size)
//   m_r*                      AXI read data channel
//   err_rresp                 sticky read-response error flag
module dma_r_ami #(
    parameter int AXI_DW = 128,
    parameter int AXI_IW = 4,
    parameter int AXI_BL = 16,
    parameter int OUTS   = 4
) (
    input  logic              usr_clk,
    input  logic              usr_reset,
    input  logic              dmar_valid,
    output logic              dmar_ready,
    input  logic [31:0]       dmar_sa,
    input  logic [31:0]       dmar_len,
    output logic [AXI_DW-1:0] dma_rdata,
    output logic              dma_rlast,
    output logic              dma_rvalid,
    input  logic              dma_rready,
    output logic [AXI_IW-1:0] m_arid,
    output logic [31:0]       m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [AXI_DW-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              err_rresp
);

    localparam int BYTES = AXI_DW / 8;
    localparam int L     = $clog2(BYTES);
    localparam int AW    = 32 - L;
    localparam logic [3:0] OUTS_L = 4'(OUTS);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_nxt;
    logic [32:0] rem;
    logic [32:0] rem_nxt;
    logic [3:0]  outs;
    logic [3:0]  outs_nxt;

    logic        busy;
    logic        ar_hs;
    logic        r_hs;
    logic        r_last_hs;
    logic [32:0] cmd_beats;
    logic [32:0] cur_b;
    logic [11:0] next_off;
    logic [12:0] page_left;
    logic [32:0] next_b;
    logic        unused_bits;

    assign busy      = (state != IDLE);
    assign ar_hs     = m_arvalid & m_arready;
    assign r_hs      = m_rvalid & m_rready;
    assign r_last_hs = r_hs & m_rlast;

    // Byte length rounded up to whole beats; 33 bits so len near 2^32 cannot wrap.
    assign cmd_beats = ({1'b0, dmar_len} + 33'(BYTES - 1)) >> L;

    // The burst currently on the AR bus; its size is recovered from m_arlen.
    assign cur_b = 33'(m_arlen) + 33'd1;

    // Command and read-data interfaces
    assign dmar_ready = (state == IDLE);
    assign dma_rdata  = m_rdata;
    assign dma_rvalid = m_rvalid & busy;
    assign m_rready   = dma_rready & busy;
    assign dma_rlast  = dma_rvalid & m_rlast & (state == DRAIN) & (outs == 4'd1);

    // Constant AR attributes
    assign m_arid    = '0;
    assign m_arsize  = 3'(L);
    assign m_arburst = 2'b01;

    // Next-state, next burst pointer and outstanding count
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        rem_nxt   = rem;
        case (state)
            IDLE: begin
                if (dmar_valid && (cmd_beats != '0)) begin
                    state_nxt = ADDR;
                    addr_nxt  = dmar_sa[31:L];
                    rem_nxt   = cmd_beats;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    addr_nxt = addr + AW'(cur_b);
                    rem_nxt  = rem - cur_b;
                    if (rem_nxt == '0) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (dma_rlast && dma_rready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        outs_nxt = outs;
        if (ar_hs && !r_last_hs) begin
            outs_nxt = outs + 4'd1;
        end else if (!ar_hs && r_last_hs) begin
            outs_nxt = outs - 4'd1;
        end
    end

    // Size of the burst that starts at addr_nxt: limited by the remaining
    // beats, the burst length cap and the distance to the next 4 KB page.
    always_comb begin
        next_off  = 12'(32'(addr_nxt) << L);
        page_left = 13'd4096 - {1'b0, next_off};
        next_b    = rem_nxt;
        if (next_b > 33'(AXI_BL)) begin
            next_b = 33'(AXI_BL);
        end
        if (next_b > 33'(page_left >> L)) begin
            next_b = 33'(page_left >> L);
        end
    end

    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // AR fields are registered from the next-cycle pointer, so they only move
    // on a command accept or an AR handshake and stay put while stalled.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            addr      <= '0;
            rem       <= '0;
            outs      <= '0;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            m_arlen   <= '0;
        end else begin
            addr      <= addr_nxt;
            rem       <= rem_nxt;
            outs      <= outs_nxt;
            m_arvalid <= (state_nxt == ADDR) && (outs_nxt < OUTS_L);
            m_araddr  <= 32'(addr_nxt) << L;
            m_arlen   <= (rem_nxt == '0) ? '0 : 8'(next_b - 33'd1);
        end
    end

`ifdef DMA_R_AMI_RRESP_CHK_EN
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            err_rresp <= 1'b0;
        end else if (r_hs && m_rresp[1]) begin
            err_rresp <= 1'b1;
        end
    end

    assign unused_bits = ^{dmar_sa[L-1:0], m_rresp[0]};
`else
    assign err_rresp   = 1'b0;
    assign unused_bits = ^{dmar_sa[L-1:0], m_rresp};
`endif

endmodule

// File: tb/tb_dma_r_ami.sv
`timescale 1ns/1ps
module tb_dma_r_ami;

    localparam int DW    = 128;
    localparam int BL    = 16;
    localparam int NOUTS = 2;
    localparam int BY    = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dmar_valid = 1'b0;
    logic          dmar_ready;
    logic [31:0]   dmar_sa = '0;
    logic [31:0]   dmar_len = '0;
    logic [DW-1:0] dma_rdata;
    logic          dma_rlast;
    logic          dma_rvalid;
    logic          dma_rready = 1'b0;
    logic [3:0]    m_arid;
    logic [31:0]   m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid;
    logic          m_arready = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = '0;
    logic          m_rlast = 1'b0;
    logic          m_rvalid = 1'b0;
    logic          m_rready;
    logic          err_rresp;

    always #5 clk = ~clk;

    dma_r_ami #(
        .AXI_DW(DW),
        .AXI_IW(4),
        .AXI_BL(BL),
        .OUTS(NOUTS)
    ) dut (
        .usr_clk(clk),
        .usr_reset(rst),
        .dmar_valid(dmar_valid),
        .dmar_ready(dmar_ready),
        .dmar_sa(dmar_sa),
        .dmar_len(dmar_len),
        .dma_rdata(dma_rdata),
        .dma_rlast(dma_rlast),
        .dma_rvalid(dma_rvalid),
        .dma_rready(dma_rready),
        .m_arid(m_arid),
        .m_araddr(m_araddr),
        .m_arlen(m_arlen),
        .m_arsize(m_arsize),
        .m_arburst(m_arburst),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_rdata(m_rdata),
        .m_rresp(m_rresp),
        .m_rlast(m_rlast),
        .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .err_rresp(err_rresp)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_err  = 1'b0;

    // Reference burst plan for the current command
    logic [31:0] exp_addr [$];
    int          exp_blen [$];
    // Observations of the last run
    logic [31:0] obs_addr [$];
    int          obs_len  [$];
    int          beats_seen;
    int          lasts_seen;
    int          ar_at9;

    function automatic logic [DW-1:0] pat(input logic [31:0] a, input logic [31:0] s);
        return {a ^ s, ~a, a + s, a ^ 32'hA5A5_5A5A};
    endfunction

    // Split a command into bursts: min(remaining, BL, beats left in 4 KB page)
    task automatic plan(input logic [31:0] sa, input logic [31:0] len, output int total);
        longint unsigned beats, a, page, b;
        exp_addr.delete();
        exp_blen.delete();
        beats = ({32'b0, len} + 64'(BY - 1)) / 64'(BY);
        total = int'(beats);
        a = {32'b0, sa} & ~64'(BY - 1);
        while (beats > 0) begin
            page = (64'd4096 - (a % 64'd4096)) / 64'(BY);
            b = beats;
            if (b > 64'(BL)) b = 64'(BL);
            if (b > page) b = page;
            exp_addr.push_back(a[31:0]);
            exp_blen.push_back(int'(b));
            a = a + b * 64'(BY);
            beats = beats - b;
        end
    endtask

    // Issue one command and play the AXI slave, checking every cycle.
    task automatic run_cmd(input string tag, input logic [31:0] sa, input logic [31:0] len,
                           input int arr_pct, input int rr_pct, input int rv_pct,
                           input int r_hold, input int err_beat, input int abort_cyc,
                           input int min_cyc);
        int total, issued, rx, bidx, outs, cyc, limit;
        int burst_q [$];
        logic [31:0] seed, base;
        logic rv, pend, exp_arv, exp_last, exp_rr;
        logic [DW-1:0] exp_data;
        plan(sa, len, total);
        seed = $urandom;
        base = sa & ~32'(BY - 1);
        issued = 0; rx = 0; bidx = 0; outs = 0; cyc = 0; pend = 1'b0;
        obs_addr.delete(); obs_len.delete();
        beats_seen = 0; lasts_seen = 0; ar_at9 = 0;
        limit = 64 + total * 24;

        @(negedge clk);
        dmar_valid = 1'b1; dmar_sa = sa; dmar_len = len;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; dma_rready = 1'b0;
        #1;
        n_checks++;
        if (dmar_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s cmd_ready: got %b want 1", tag, dmar_ready);
        end
        n_checks++;
        if (m_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL %s arvalid_at_accept: got %b want 0", tag, m_arvalid);
        end

        while ((rx < total || cyc < min_cyc) && cyc != abort_cyc) begin
            if (cyc >= limit) begin
                n_checks++; n_fail++;
                $display("FAIL %s timeout: got %0d beats want %0d", tag, rx, total);
                break;
            end
            @(negedge clk);
            dmar_valid = 1'b0; dmar_sa = $urandom; dmar_len = $urandom;
            m_arready  = ($urandom_range(99) < arr_pct);
            dma_rready = ($urandom_range(99) < rr_pct);
            if (pend) rv = 1'b1;
            else rv = (cyc >= r_hold) && (burst_q.size() > 0) && ($urandom_range(99) < rv_pct);
            m_rvalid = rv;
            if (rv) begin
                m_rdata = pat(base + 32'(rx * BY), seed);
                m_rlast = (bidx == burst_q[0] - 1);
                m_rresp = (rx == err_beat) ? 2'b10 : 2'b00;
            end else begin
                m_rdata = {$urandom, $urandom, $urandom, $urandom};
                m_rlast = 1'($urandom);
                m_rresp = 2'b00;
            end
            #1;
            n_checks++;
            if (dma_rvalid !== rv) begin
                n_fail++; $display("FAIL %s rvalid: got %b want %b (beat %0d)", tag, dma_rvalid, rv, rx);
            end
            exp_rr = (total > 0) && dma_rready;
            n_checks++;
            if (m_rready !== exp_rr) begin
                n_fail++; $display("FAIL %s m_rready: got %b want %b", tag, m_rready, exp_rr);
            end
            exp_arv = (issued < exp_addr.size()) && (outs < NOUTS);
            n_checks++;
            if (m_arvalid !== exp_arv) begin
                n_fail++; $display("FAIL %s arvalid: got %b want %b (cyc %0d outs %0d)", tag, m_arvalid, exp_arv, cyc, outs);
            end
            exp_last = rv && (rx == total - 1);
            n_checks++;
            if (dma_rlast !== exp_last) begin
                n_fail++; $display("FAIL %s rlast: got %b want %b (beat %0d)", tag, dma_rlast, exp_last, rx);
            end
            n_checks++;
            if (err_rresp !== exp_err) begin
                n_fail++; $display("FAIL %s err_rresp: got %b want %b", tag, err_rresp, exp_err);
            end
            if (rv) begin
                exp_data = pat(base + 32'(rx * BY), seed);
                n_checks++;
                if (dma_rdata !== exp_data) begin
                    n_fail++; $display("FAIL %s rdata beat %0d: got %h want %h", tag, rx, dma_rdata, exp_data);
                end
            end
            if (m_arvalid && m_arready) begin
                obs_addr.push_back(m_araddr);
                obs_len.push_back(int'(m_arlen));
                if (issued < exp_addr.size()) begin
                    n_checks++;
                    if (m_araddr !== exp_addr[issued] || m_arlen !== 8'(exp_blen[issued] - 1)) begin
                        n_fail++;
                        $display("FAIL %s ar%0d: got %h/%0d want %h/%0d", tag, issued, m_araddr, m_arlen,
                                 exp_addr[issued], exp_blen[issued] - 1);
                    end
                    burst_q.push_back(exp_blen[issued]);
                    issued++;
                    outs++;
                end
            end
            if (rv && dma_rready) begin
                beats_seen++;
                if (dma_rlast) lasts_seen++;
`ifdef DMA_R_AMI_RRESP_CHK_EN
                if (m_rresp[1]) exp_err = 1'b1;
`endif
                if (m_rlast) begin
                    void'(burst_q.pop_front());
                    bidx = 0;
                    outs--;
                end else begin
                    bidx++;
                end
                rx++;
                pend = 1'b0;
            end else begin
                pend = rv;
            end
            if (cyc == 9) ar_at9 = obs_addr.size();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_rvalid = 1'b1; m_rlast = 1'b1; dma_rready = 1'b1; m_rresp = 2'b10;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (m_arvalid !== 1'b0 || m_araddr !== 32'h0 || m_arlen !== 8'h0) begin
            n_fail++; $display("FAIL reset_ar: got %b/%h/%h want 0/0/0", m_arvalid, m_araddr, m_arlen);
        end
        n_checks++;
        if (dma_rvalid !== 1'b0 || dma_rlast !== 1'b0 || m_rready !== 1'b0) begin
            n_fail++; $display("FAIL reset_r: got %b/%b/%b want 0/0/0", dma_rvalid, dma_rlast, m_rready);
        end
        n_checks++;
        if (err_rresp !== 1'b0 || dmar_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_misc: err %b ready %b want 0/1", err_rresp, dmar_ready);
        end
        n_checks++;
        if (m_arid !== 4'h0 || m_arsize !== 3'd4 || m_arburst !== 2'b01) begin
            n_fail++; $display("FAIL ar_const: got %h/%0d/%b want 0/4/01", m_arid, m_arsize, m_arburst);
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; dma_rready = 1'b0; m_rresp = 2'b00;
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_single_burst();
        run_cmd("single", 32'h0000_1000, 32'd256, 100, 100, 100, 0, -1, -1, 0);
        n_checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 32'h1000 || obs_len[0] != 15) begin
            n_fail++; $display("FAIL single_ar: got %0d ARs first %h/%0d want 1 AR 1000/15",
                               obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 32'h0,
                               obs_len.size() > 0 ? obs_len[0] : -1);
        end
        n_checks++;
        if (beats_seen != 16 || lasts_seen != 1) begin
            n_fail++; $display("FAIL single_beats: got %0d beats %0d lasts want 16/1", beats_seen, lasts_seen);
        end
    endtask

    task automatic test_4k_split();
        run_cmd("split4k", 32'h0000_1F80, 32'd512, 100, 100, 100, 0, -1, -1, 0);
        n_checks++;
        if (obs_addr.size() != 3) begin
            n_fail++; $display("FAIL split_count: got %0d ARs want 3", obs_addr.size());
        end else if (obs_addr[0] !== 32'h1F80 || obs_len[0] != 7 || obs_addr[1] !== 32'h2000 ||
                     obs_len[1] != 15 || obs_addr[2] !== 32'h2100 || obs_len[2] != 7) begin
            n_fail++; $display("FAIL split_ars: got %h/%0d %h/%0d %h/%0d want 1f80/7 2000/15 2100/7",
                               obs_addr[0], obs_len[0], obs_addr[1], obs_len[1], obs_addr[2], obs_len[2]);
        end
        n_checks++;
        if (beats_seen != 32 || lasts_seen != 1) begin
            n_fail++; $display("FAIL split_beats: got %0d beats %0d lasts want 32/1", beats_seen, lasts_seen);
        end
    endtask

    task automatic test_odd_len();
        run_cmd("odd", 32'h0000_200F, 32'd17, 80, 80, 80, 0, -1, -1, 0);
        n_checks++;
        if (obs_addr.size() != 1 || obs_len[0] != 1 || obs_addr[0] !== 32'h2000) begin
            n_fail++; $display("FAIL odd_ar: got %0d ARs want 1 AR 2000/1", obs_addr.size());
        end
    endtask

    task automatic test_zero_len();
        run_cmd("zero", 32'h0000_3000, 32'd0, 100, 100, 100, 0, -1, -1, 6);
        n_checks++;
        if (obs_addr.size() != 0 || beats_seen != 0) begin
            n_fail++; $display("FAIL zero_len: got %0d ARs %0d beats want 0/0", obs_addr.size(), beats_seen);
        end
        n_checks++;
        if (dmar_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_ready: got %b want 1", dmar_ready);
        end
    endtask

    task automatic test_outs_limit();
        run_cmd("outs", 32'h0004_0000, 32'd1024, 100, 100, 100, 10, -1, -1, 0);
        n_checks++;
        if (ar_at9 != NOUTS) begin
            n_fail++; $display("FAIL outs_limit: got %0d ARs while R stalled want %0d", ar_at9, NOUTS);
        end
        n_checks++;
        if (obs_addr.size() != 4 || beats_seen != 64) begin
            n_fail++; $display("FAIL outs_total: got %0d ARs %0d beats want 4/64", obs_addr.size(), beats_seen);
        end
    endtask

    task automatic test_backpressure();
        run_cmd("bp", 32'h0003_0000, 32'd1024, 60, 50, 80, 0, -1, -1, 0);
        n_checks++;
        if (beats_seen != 64 || lasts_seen != 1) begin
            n_fail++; $display("FAIL bp_beats: got %0d beats %0d lasts want 64/1", beats_seen, lasts_seen);
        end
    endtask

    task automatic test_rresp();
        logic want;
        run_cmd("rresp", 32'h0000_5000, 32'd128, 100, 100, 100, 0, 2, -1, 0);
        n_checks++;
        if (beats_seen != 8) begin
            n_fail++; $display("FAIL rresp_beats: got %0d want 8", beats_seen);
        end
`ifdef DMA_R_AMI_RRESP_CHK_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        m_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            n_checks++;
            if (err_rresp !== want) begin
                n_fail++; $display("FAIL rresp_hold: got %b want %b", err_rresp, want);
            end
        end
        rst = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (err_rresp !== 1'b0) begin
            n_fail++; $display("FAIL rresp_clear: got %b want 0", err_rresp);
        end
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_mid_reset();
        run_cmd("midrst", 32'h0006_0F00, 32'd2048, 100, 100, 100, 3, -1, 6, 0);
        rst = 1'b1; m_rvalid = 1'b0; m_arready = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (m_arvalid !== 1'b0 || m_araddr !== 32'h0 || m_arlen !== 8'h0 || dmar_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_state: got %b/%h/%h ready %b want 0/0/0 ready 1",
                               m_arvalid, m_araddr, m_arlen, dmar_ready);
        end
        rst = 1'b0;
        exp_err = 1'b0;
        run_cmd("midrst_after", 32'h0000_7000, 32'd96, 100, 100, 100, 0, -1, -1, 0);
        n_checks++;
        if (beats_seen != 6 || lasts_seen != 1) begin
            n_fail++; $display("FAIL midrst_after: got %0d beats %0d lasts want 6/1", beats_seen, lasts_seen);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            run_cmd("b2b", $urandom & 32'h00FF_FFFF, 32'($urandom_range(1, 700)), 100, 100, 100, 0, -1, -1, 0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_cmd("random", $urandom & 32'h0FFF_FFFF, 32'($urandom_range(1, 1200)), 70, 70, 70, 0, -1, -1, 0);
            repeat ($urandom_range(2)) @(negedge clk);
        end
        @(negedge clk); #1;
        n_checks++;
        if (dmar_ready !== 1'b1) begin
            n_fail++; $display("FAIL final_ready: got %b want 1", dmar_ready);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_4k_split();
        test_odd_len();
        test_zero_len();
        test_outs_limit();
        test_backpressure();
        test_rresp();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
